// File: rtl/lsa_uart_tx.sv
// Memory-mapped 8N1 serial transmitter for the lsa_core bus: TXDATA/STATUS registers,
// a small TX FIFO and a start/data/stop serialiser driving tx_out (idle high).
module lsa_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic [15:0] mem_add,
  input  logic [15:0] mem_in,
  input  logic        mem_we,
  input  logic        mem_oe,
  input  logic        mem_fetch,
  output logic [15:0] mem_out,
  output logic        tx_out
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast   = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull    = CntW'(FIFO_DEPTH);
  localparam logic [15:0]      StatusAddr = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr, wr_ptr;
  logic [CntW-1:0]   count;
  logic              overflow;
  logic [BaudW-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;

  logic        sel, is_status, full, empty, busy, baud_done;
  logic        pop, push_req, push, clr_ovf;
  logic [15:0] status;
  logic        unused_bits;

  assign unused_bits = ^mem_in[15:8];

  always_comb begin
    sel       = ((mem_add == BASE_ADDR) || (mem_add == StatusAddr)) && !mem_fetch;
    is_status = (mem_add == StatusAddr);
    full      = (count == CntFull);
    empty     = (count == '0);
    busy      = (state != StIdle);
    baud_done = (baud_cnt == BaudLast);
    // Pops happen only where the serialiser loads a new byte: idle, or the final stop cycle.
    pop       = !empty && ((state == StIdle) || ((state == StStop) && baud_done));
    push_req  = sel && mem_we && !is_status;
    push      = push_req && (!full || pop);
    clr_ovf   = sel && mem_we && is_status && mem_in[3];
    status    = {7'd0, 5'(count), overflow, busy, empty, full};
  end

  always_ff @(posedge clock_in) begin
    if (push) fifo_mem[wr_ptr] <= mem_in[7:0];
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state    <= StIdle;
      tx_out   <= 1'b1;
      mem_out  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      mem_out <= (sel && mem_oe && is_status) ? status : 16'd0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CntW'(push) - CntW'(pop);
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)             overflow <= 1'b0;

      unique case (state)
        StIdle: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shift  <= fifo_mem[rd_ptr];
            tx_out <= 1'b0;
            state  <= StStart;
          end else begin
            tx_out <= 1'b1;
          end
        end
        StStart: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx_out   <= shift[0];
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        StData: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_out <= 1'b1;
              state  <= StStop;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= shift[1];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        StStop: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            // Chain straight into the next start bit so queued frames are contiguous.
            if (pop) begin
              shift  <= fifo_mem[rd_ptr];
              tx_out <= 1'b0;
              state  <= StStart;
            end else begin
              state  <= StIdle;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsa_uart_tx.sv
// Directed bench for lsa_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4): register decode table,
// frame timing, FIFO overflow/back-to-back and mid-frame reset sequences.
module tb_lsa_uart_tx;

  localparam int          Cpb  = 4;
  localparam logic [15:0] Base = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] add, din, dout;
  logic        we, oe, fetch, tx;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic tx_log [0:2047];
  logic [7:0] exp_bytes [8];

  typedef struct {
    logic [15:0] add;
    logic [15:0] din;
    logic        we;
    logic        oe;
    logic        fetch;
    logic [15:0] exp_out;
    logic        exp_tx;
  } vec_t;
  vec_t vecs [12];

  lsa_uart_tx #(
    .BASE_ADDR   (Base),
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (4)
  ) dut (
    .clock_in (clk),
    .reset_in (reset),
    .mem_add  (add),
    .mem_in   (din),
    .mem_we   (we),
    .mem_oe   (oe),
    .mem_fetch(fetch),
    .mem_out  (dout),
    .tx_out   (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // tx_log[n] holds tx_out as it stands after rising edge number n.
  always @(negedge clk) if (cyc < 2048) tx_log[cyc] <= tx;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    add = a; din = d; we = 1'b1;
    tick;
    we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] exp);
    add = Base + 16'd1; oe = 1'b1;
    tick;
    oe = 1'b0;
    chk(name, dout, exp);
  endtask

  // Counts line samples that differ from n contiguous frames starting after edge s.
  task automatic check_frames(input string name, input int s, input int n);
    int   bad;
    logic e;
    bad = 0;
    if (tx_log[s-1] !== 1'b1) bad++;
    for (int f = 0; f < n; f++)
      for (int j = 0; j < 10; j++)
        for (int k = 0; k < Cpb; k++) begin
          if (j == 0)      e = 1'b0;
          else if (j == 9) e = 1'b1;
          else             e = exp_bytes[f][j-1];
          if (tx_log[s + 40*f + Cpb*j + k] !== e) bad++;
        end
    if (tx_log[s + 40*n] !== 1'b1) bad++;
    chk(name, 16'(bad), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0, s, r, bad;

    vecs[0]  = '{16'hFF01, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1};
    vecs[1]  = '{16'hFF00, 16'h0077, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[2]  = '{16'hFF01, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1};
    vecs[3]  = '{16'hFF02, 16'h0033, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[4]  = '{16'hFF01, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1};
    vecs[5]  = '{16'hFF00, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[6]  = '{16'hFF01, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[7]  = '{16'hFF02, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[8]  = '{16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[9]  = '{16'hFEFF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[10] = '{16'hFF01, 16'h0008, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[11] = '{16'hFF01, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1};

    // Reset, with a status read pending to show reset wins.
    reset = 1'b1; add = Base + 16'd1; din = '0; we = 1'b0; oe = 1'b1; fetch = 1'b0;
    tick;
    tick;
    chk("rst_mem_out", dout, 16'h0000);
    chk("rst_tx", {15'd0, tx}, 16'd1);
    reset = 1'b0; oe = 1'b0;
    rd_chk("rst_status", 16'h0002);

    // Single frame of 8'h55; status read continuously during it.
    wr(Base, 16'h1255);
    w0 = cyc;
    chk("lat_pre", {15'd0, tx}, 16'd1);
    add = Base + 16'd1; oe = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      tick;
      if (i == 1) begin
        chk("lat_fall", {15'd0, tx}, 16'd0);
        chk("st_pending", dout, 16'h0010);
      end
      if (i == 20) chk("st_busy_mid", dout, 16'h0006);
      if (i == 41) chk("st_busy_stop", dout, 16'h0006);
      if (i == 42) begin
        chk("st_idle_after", dout, 16'h0002);
        chk("tx_idle_after", {15'd0, tx}, 16'd1);
      end
    end
    oe = 1'b0;
    exp_bytes[0] = 8'h55;
    check_frames("frame_55", w0 + 1, 1);

    // Three back-to-back frames.
    wr(Base, 16'h00A1);
    w0 = cyc;
    wr(Base, 16'h00B2);
    wr(Base, 16'h00C3);
    rd_chk("count2", 16'h0024);
    while (cyc < w0 + 1 + 120 + 2) tick;
    exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2; exp_bytes[2] = 8'hC3;
    check_frames("frames_abc", w0 + 1, 3);

    // Overflow: one byte in flight, four fill the FIFO, the fifth is dropped.
    wr(Base, 16'h0011);
    w0 = cyc;
    wr(Base, 16'h0021);
    wr(Base, 16'h0022);
    wr(Base, 16'h0023);
    wr(Base, 16'h0024);
    wr(Base, 16'h0025);
    add = Base + 16'd1; din = 16'h0008; we = 1'b1; oe = 1'b1;
    tick;
    we = 1'b0; oe = 1'b0;
    chk("ovf_set_prewrite", dout, 16'h004D);
    rd_chk("ovf_cleared", 16'h0045);
    // Push while full on the stop-bit pop edge must be accepted.
    while (cyc < w0 + 40) tick;
    wr(Base, 16'h0026);
    rd_chk("full_push_pop", 16'h0045);
    s = w0 + 1;
    while (cyc < s + 240 + 2) tick;
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h21; exp_bytes[2] = 8'h22;
    exp_bytes[3] = 8'h23; exp_bytes[4] = 8'h24; exp_bytes[5] = 8'h26;
    check_frames("frames_ovf", s, 6);
    rd_chk("drained", 16'h0002);

    // Decode table: fetch-qualified, off-range and data-register accesses.
    for (int i = 0; i < 12; i++) begin
      add = vecs[i].add; din = vecs[i].din; we = vecs[i].we;
      oe = vecs[i].oe; fetch = vecs[i].fetch;
      tick;
      we = 1'b0; oe = 1'b0; fetch = 1'b0;
      chk($sformatf("vec%0d_mem_out", i), dout, vecs[i].exp_out);
      chk($sformatf("vec%0d_tx", i), {15'd0, tx}, {15'd0, vecs[i].exp_tx});
    end

    // Reset during data bit 2 (a 0) with two bytes still queued.
    wr(Base, 16'h005A);
    w0 = cyc;
    wr(Base, 16'h003C);
    wr(Base, 16'h0096);
    s = w0 + 1;
    while (cyc < s + 13) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    r = cyc;
    chk("pre_rst_bit", {15'd0, tx_log[s + 13]}, 16'd0);
    chk("rst_abort_tx", {15'd0, tx}, 16'd1);
    rd_chk("rst_abort_status", 16'h0002);
    repeat (50) tick;
    bad = 0;
    for (int i = r; i < r + 50; i++) if (tx_log[i] !== 1'b1) bad++;
    chk("rst_no_frames", 16'(bad), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
